// File: rtl/spi_master_half_duplex.sv
// Half-duplex SPI master, mode 0: sends a 16-bit command on the shared
// data line, then turns the line around and reads a 16-bit response.
module spi_master_half_duplex #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] tx_data,
    output logic [15:0] rx_data,
    output logic        busy,
    output logic        done,
    output logic        spi_clk,
    output logic        spi_cs,
    inout  wire         spi_io
);

    typedef enum logic [1:0] {IDLE, SETUP, WRITE, READ} state_t;

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] div;
    logic [6:0]    phase;
    logic [15:0]   tx_sh;
    logic [15:0]   rx_sh;
    logic          io_oe;
    logic          tick;
    logic          accept;
    logic          last;

    assign tick   = (state != IDLE) && (div == DW'(CLK_DIV - 1));
    assign accept = (state == IDLE) && start && !done;
    assign last   = tick && (phase == 7'd64);
    assign busy   = (state != IDLE) || done;
    assign spi_io = io_oe ? tx_sh[15] : 1'bz;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   if (tick) state_nxt = WRITE;
            WRITE:   if (tick && phase == 7'd31) state_nxt = READ;
            READ:    if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div     <= '0;
            phase   <= '0;
            spi_cs  <= 1'b1;
            spi_clk <= 1'b0;
            io_oe   <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                tx_sh  <= tx_data;
                spi_cs <= 1'b0;
                io_oe  <= 1'b1;
                div    <= '0;
                phase  <= '0;
            end else if (state != IDLE) begin
                if (tick) begin
                    div <= '0;
                    if (last) begin
                        phase   <= '0;
                        spi_cs  <= 1'b1;
                        spi_clk <= 1'b0;
                        rx_data <= rx_sh;
                        done    <= 1'b1;
                    end else begin
                        phase   <= phase + 7'd1;
                        // entering an odd phase raises spi_clk
                        spi_clk <= ~phase[0];
                    end
                    if (state == WRITE && phase[0] && phase < 7'd31)
                        tx_sh <= {tx_sh[14:0], 1'b0};
                    if (phase == 7'd31)
                        io_oe <= 1'b0;
                    // sample just before each read-half rising edge
                    if (state == READ && !phase[0] && phase <= 7'd62)
                        rx_sh <= {rx_sh[14:0], spi_io};
                end else begin
                    div <= div + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/spi_master_half_duplex.md
SPI_MASTER_HALF_DUPLEX -- requirements
Module: spi_master_half_duplex

Interface
REQ-001 Parameter CLK_DIV, default 4, meaning clk cycles per spi_clk half-period; legal range >= 1.
REQ-002 Port clk, input, 1, meaning system clock; all logic SHALL sample on its rising edge.
REQ-003 Port rst, input, 1, meaning reset, synchronous to clk and active-high.
REQ-004 Port start, input, 1, meaning single-cycle request to begin a transaction.
REQ-005 Port tx_data, input, 16, meaning command word sent MSB-first.
REQ-006 Port rx_data, output, 16, meaning response word, MSB-first, held until the next done.
REQ-007 Port busy, output, 1, meaning high from start acceptance until the done cycle, inclusive.
REQ-008 Port done, output, 1, meaning one-cycle pulse that marks rx_data valid.
REQ-009 Port spi_clk, output, 1, meaning serial clock, idle low, mode 0.
REQ-010 Port spi_cs, output, 1, meaning active-low chip select.
REQ-011 Port spi_io, inout, 1, meaning shared data line; high-Z whenever the output enable io_oe=0.

Function
REQ-012 States SHALL be IDLE, SETUP, WRITE, READ.
REQ-013 A half-period tick SHALL fire when the divider counter equals CLK_DIV-1; the divider SHALL count only outside IDLE.
REQ-014 A 7-bit phase counter SHALL number half-periods: phase 0 is SETUP, phases 1..64 alternate with odd=spi_clk high and even=spi_clk low.
REQ-015 IDLE with start=1: the block SHALL latch tx_data, set spi_cs=0, io_oe=1, spi_io=tx_data[15], busy=1, and enter SETUP on the next cycle.
REQ-016 start SHALL be ignored while busy=1, with no effect on the shift registers.
REQ-017 spi_clk SHALL change only on ticks; it SHALL rise at the start of each odd phase and fall at the start of each even phase.
REQ-018 WRITE covers phases 1..31: at the start of phase 2k (k=1..15), spi_io SHALL present tx bit 15-k, so data is stable across each rising edge.
REQ-019 At the start of phase 32 (the falling edge after the 16th rising edge), io_oe SHALL drop to 0 and the state SHALL become READ; the master SHALL NOT drive spi_io again until the next transaction.
REQ-020 READ: at each tick ending phases 32, 34, ..., 62, spi_io SHALL be shifted into an rx shift register LSB-in, giving 16 samples, one before each of rising edges 17..32.
REQ-021 At the tick ending phase 64: spi_cs=1, spi_clk=0, rx_data=rx shift register, done=1 for one cycle, busy=0 in the following cycle, state=IDLE.
REQ-022 Latency from the start-accept edge to the done cycle SHALL be 65*CLK_DIV cycles.
REQ-023 Back-to-back: start asserted in the cycle after done SHALL be accepted; spi_cs high time is then 1 clk minimum.
REQ-024 spi_io SHALL NOT be driven while spi_cs=1.

Reset
REQ-025 rst=1 SHALL, on the next clk edge, force: state=IDLE, spi_cs=1, spi_clk=0, io_oe=0, busy=0, done=0, rx_data=16'h0000, counters=0.
REQ-026 rst mid-transaction SHALL abort without asserting done and SHALL raise spi_cs in the same edge.
REQ-027 rst has priority over start in the same cycle.

Verification
REQ-028 Slave model (returns 16'hCC33 after 16 received bits), CLK_DIV=4, tx_data=16'hA5F0, start pulse -> the slave captures 16'hA5F0; done fires exactly 260 cycles after start; rx_data=16'hCC33.
REQ-029 Bus contention check across the full transaction -> spi_io is never X; io_oe=0 from phase 32 onward; exactly 32 rising edges on spi_clk per spi_cs low window.
REQ-030 CLK_DIV=1, tx_data=16'h0001 -> done after 65 cycles; rx_data=16'hCC33; the last write bit is 1.
REQ-031 start pulsed again at phase 10 -> ignored; the single transaction completes normally with rx_data=16'hCC33.
REQ-032 rst asserted at phase 40 -> next edge spi_cs=1, busy=0, no done; a new start then yields rx_data=16'hCC33.
REQ-033 Two back-to-back starts (second one cycle after done) with tx 16'h1234 then 16'hFFFF -> two done pulses; both rx_data=16'hCC33; the slave sees each word.
